// File: rtl/esp_uart_rx_ci_if.sv
// Custom-instruction port between the Nios II (master) and the ESP UART receiver (slave).
interface esp_uart_rx_ci_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] result;
    logic        done;

    modport master (output clk_en, start, dataA, dataB, input result, done);
    modport slave  (input clk_en, start, dataA, dataB, output result, done);
endinterface

// File: rtl/esp_uart_rx_ci.sv
// 8N1 UART receiver for the ESP8266 link with a byte FIFO, read by the Nios II
// through a latency-1 custom instruction (POP / STATUS / CLEAR).
module esp_uart_rx_ci #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    esp_uart_rx_ci_if.slave   ci
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam int NW           = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {OP_POP, OP_STATUS, OP_CLEAR, OP_RSVD} ci_op_t;

    logic            rx_meta, rxs;
    rx_state_t       state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic            ovf, ferr;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    logic half_done, bit_done, stop_sample, rx_push, rx_ferr;
    assign half_done   = (baud_cnt == CW'(HALF_BIT - 1));
    assign bit_done    = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign stop_sample = (state == STOP) && bit_done;
    assign rx_push     = stop_sample && rxs;
    assign rx_ferr     = stop_sample && !rxs;

    // NOTE: every register in a clocked block uses <=, so all reads see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: if (!rxs) begin
                    state    <= START;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                START: if (half_done) begin
                    baud_cnt <= '0;
                    state    <= rxs ? IDLE : DATA;
                end else begin
                    baud_cnt <= baud_cnt + CW'(1);
                end
                DATA: if (bit_done) begin
                    baud_cnt <= '0;
                    shift    <= {rxs, shift[7:1]};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= STOP;
                end else begin
                    baud_cnt <= baud_cnt + CW'(1);
                end
                STOP: if (bit_done) begin
                    baud_cnt <= '0;
                    state    <= IDLE;
                end else begin
                    baud_cnt <= baud_cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    ci_op_t op;
    logic   ci_go, empty, full, do_clear, do_pop, do_push;
    assign op       = ci_op_t'(ci.dataA[1:0]);
    assign ci_go    = ci.clk_en && ci.start;
    assign empty    = (count == '0);
    assign full     = (count == NW'(FIFO_DEPTH));
    assign do_clear = ci_go && (op == OP_CLEAR);
    assign do_pop   = ci_go && (op == OP_POP) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push  = rx_push && !do_clear && (!full || do_pop);

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + NW'(do_push) - NW'(do_pop);
            if (rx_push && full && !do_pop) ovf <= 1'b1;
            if (rx_ferr) ferr <= 1'b1;
        end
    end

    logic [7:0] count8;
    assign count8 = 8'(count);

    always_ff @(posedge clk) begin
        if (reset) begin
            ci.result <= '0;
            ci.done   <= 1'b0;
        end else begin
            ci.done <= ci_go;
            if (ci_go) begin
                case (op)
                    OP_POP:    ci.result <= empty ? 32'd0 : {23'd0, 1'b1, mem[rd_ptr]};
                    OP_STATUS: ci.result <= {16'd0, count8, 5'd0, ferr, ovf, !empty};
                    default:   ci.result <= '0;
                endcase
            end
        end
    end

    logic unused_ci_bits;
    assign unused_ci_bits = ^{ci.dataA[31:2], ci.dataB};
endmodule

// File: tb/tb_esp_uart_rx_ci.sv
// Self-checking bench for esp_uart_rx_ci: a queue-based FIFO/flag model predicts every
// instruction result; a compare process checks done/result each cycle.
module tb_esp_uart_rx_ci;
    localparam int CLK_HZ      = 1_843_200;
    localparam int BAUD        = 115200;
    localparam int DEPTH       = 16;
    localparam int CPB         = CLK_HZ / BAUD;
    localparam int HALF        = CPB / 2;
    // 2 sync flops + 1 idle-detect cycle + half start bit + 8 data bits + 1 stop bit
    localparam int STOP_SAMPLE = 3 + HALF + 9 * CPB;
    localparam int GLITCH      = HALF / 2;

    localparam logic [1:0] OP_POP = 2'd0, OP_STATUS = 2'd1, OP_CLEAR = 2'd2, OP_RSVD = 2'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;

    esp_uart_rx_ci_if ci ();

    esp_uart_rx_ci #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .ci    (ci)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mq[$];
    logic        m_ovf = 1'b0;
    logic        m_ferr = 1'b0;
    logic [31:0] exp_res[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_exec(input logic [1:0] op, output logic [31:0] r);
        r = '0;
        case (op)
            OP_POP:    if (mq.size() != 0) r = {23'd0, 1'b1, mq.pop_front()};
            OP_STATUS: r = {16'd0, 8'(mq.size()), 5'd0, m_ferr, m_ovf, mq.size() != 0};
            OP_CLEAR:  begin mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0; end
            default:   ;
        endcase
    endtask

    task automatic drive_op(input logic [1:0] op);
        logic [31:0] a, r;
        a = $urandom();
        a[1:0] = op;
        ci.clk_en = 1'b1;
        ci.start  = 1'b1;
        ci.dataA  = a;
        ci.dataB  = $urandom();
        model_exec(op, r);
        exp_res.push_back(r);
    endtask

    task automatic issue(input logic [1:0] op, output logic [31:0] got);
        @(posedge clk); #1;
        drive_op(op);
        @(posedge clk); #1;
        ci.start  = 1'b0;
        ci.clk_en = 1'($urandom_range(0, 1));
        @(negedge clk);
        got = ci.result;
    endtask

    task automatic issue_burst(input logic [1:0] op, input int n);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            drive_op(op);
            @(posedge clk); #1;
        end
        ci.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        rx = 1'b1;
        if (!stop) m_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    // Every cycle: done must follow an accepted start by one cycle; result holds otherwise.
    logic        go_s, rst_s, exp_done;
    logic [31:0] hold = '0;
    initial begin
        forever begin
            @(posedge clk);
            rst_s = reset;
            go_s  = ci.clk_en && ci.start;
            @(negedge clk);
            exp_done = 1'b0;
            if (rst_s) begin
                hold = '0;
            end else if (go_s) begin
                exp_done = 1'b1;
                if (exp_res.size() == 0) check("expectation_queue", 32'd0, 32'd1);
                else hold = exp_res.pop_front();
            end
            check("done", {31'd0, ci.done}, {31'd0, exp_done});
            check("result", ci.result, hold);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    logic [31:0] got;

    initial begin
        ci.clk_en = 1'b0;
        ci.start  = 1'b0;
        ci.dataA  = '0;
        ci.dataB  = '0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        issue(OP_STATUS, got);
        check("reset_status", got, 32'h0000_0000);

        // start without clk_en must be ignored
        @(posedge clk); #1;
        ci.clk_en = 1'b0;
        ci.start  = 1'b1;
        ci.dataA  = {30'd0, OP_CLEAR};
        @(posedge clk); #1;
        ci.start = 1'b0;

        // single frame
        send_frame(8'hA5, 1'b1);
        issue(OP_RSVD, got);
        check("reserved_op", got, 32'h0000_0000);
        issue(OP_POP, got);
        check("pop_a5", got, 32'h0000_01A5);
        issue(OP_POP, got);
        check("pop_empty", got, 32'h0000_0000);

        // overflow: 17 bytes into a 16-deep FIFO
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        issue(OP_STATUS, got);
        check("status_full_ovf", got, 32'h0000_1003);
        issue(OP_POP, got);
        check("pop_first", got, 32'h0000_0100);
        issue_burst(OP_POP, 14);
        issue(OP_POP, got);
        check("pop_16th", got, 32'h0000_010F);
        issue(OP_POP, got);
        check("pop_17th", got, 32'h0000_0000);
        issue(OP_CLEAR, got);
        check("clear_result", got, 32'h0000_0000);

        // framing error
        send_frame(8'h3C, 1'b0);
        issue(OP_STATUS, got);
        check("status_ferr", got, 32'h0000_0004);
        issue(OP_CLEAR, got);
        issue(OP_STATUS, got);
        check("status_after_clear", got, 32'h0000_0000);

        // glitch rejection
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (GLITCH) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        issue(OP_STATUS, got);
        check("status_glitch", got, 32'h0000_0000);
        send_frame(8'h5A, 1'b1);
        issue(OP_POP, got);
        check("pop_5a", got, 32'h0000_015A);

        // push/POP collision on the stop-sample cycle
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                logic [31:0] g;
                repeat (STOP_SAMPLE - 1) @(posedge clk);
                issue(OP_POP, g);
                check("pop_collision", g, 32'h0000_0111);
            end
        join
        issue(OP_STATUS, got);
        check("status_collision", got, 32'h0000_0101);
        issue(OP_POP, got);
        check("pop_22", got, 32'h0000_0122);

        // reset in the middle of a frame with bytes queued
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        issue(OP_STATUS, got);
        check("status_three", got, 32'h0000_0301);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1 reset = 1'b1;
        mq.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", ci.result, 32'h0000_0000);
        check("reset_done", {31'd0, ci.done}, 32'd0);
        #1 reset = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        issue(OP_STATUS, got);
        check("status_after_reset", got, 32'h0000_0000);
        send_frame(8'h81, 1'b1);
        issue(OP_POP, got);
        check("pop_81", got, 32'h0000_0181);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
